weight_stream_loader: RTL

//  Parametrised BRAM-to-stream weight fetcher for any layer. On start it reads num_weights
//  W-bit words from an external read-only BRAM port, beginning at base_addr. It packs them

---
 rtl/weight_stream_loader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/weight_stream_loader.sv
// rtl/weight_stream_loader.sv - BRAM-to-stream weight fetcher with credit-gated prefetch FIFO and lane packer
// Optional checksum output enabled by defining WSL_CHECKSUM_EN.
module weight_stream_loader #(
    parameter int W          = 8,
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 15,
    parameter int CNT_WIDTH  = 16,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_weights,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [W-1:0]          bram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [LANES*W-1:0]    m_data,
    output logic                  m_last
`ifdef WSL_CHECKSUM_EN
    ,
    output logic [15:0]           checksum
`endif
);
    localparam int CW  = CNT_WIDTH + 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int FCW = PW + 1;
    localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CW-1:0]         num_q, num_d, issued_q, issued_d, popped_q, popped_d;
    logic [RD_LAT-1:0]     rd_vld_q, rd_vld_d;
    logic [FCW-1:0]        infl_q, infl_d, fcnt_q, fcnt_d;
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [W-1:0]          mem_q [FIFO_DEPTH];
    logic [W-1:0]          mem_d [FIFO_DEPTH];
    logic [LANES*W-1:0]    acc_q, acc_d, out_q, out_d, beat;
    logic [LW-1:0]         lane_q, lane_d;
    logic                  full_q, full_d, alast_q, alast_d;
    logic                  mv_q, mv_d, ml_q, ml_d;
    logic                  issue, push, pop, out_free, fin, complete;
`ifdef WSL_CHECKSUM_EN
    logic [15:0]           csum_q, csum_d;
`endif

    // A read may only issue if its word is guaranteed a FIFO slot on return
    assign issue    = (state_q == S_FETCH) && (issued_q < num_q)
                      && ((int'(fcnt_q) + int'(infl_q)) < FIFO_DEPTH);
    assign push     = rd_vld_q[RD_LAT-1];
    assign pop      = (fcnt_q != '0) && !full_q;
    assign out_free = !mv_q || m_ready;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        num_d    = num_q;
        issued_d = issued_q;
        popped_d = popped_q;
        rd_vld_d = '0;
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        acc_d    = acc_q;
        lane_d   = lane_q;
        full_d   = full_q;
        alast_d  = alast_q;
        mv_d     = mv_q && !m_ready;
        out_d    = out_q;
        ml_d     = ml_q;
        beat     = acc_q;
        fin      = 1'b0;
        complete = 1'b0;
`ifdef WSL_CHECKSUM_EN
        csum_d   = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    num_d    = CW'(num_weights);
                    issued_d = '0;
                    popped_d = '0;
`ifdef WSL_CHECKSUM_EN
                    csum_d   = '0;
`endif
                    state_d  = (num_weights == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: if (issue && (issued_q + CW'(1) == num_q)) state_d = S_DRAIN;
            S_DRAIN: if (mv_q && m_ready && ml_q) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        if (issue) issued_d = issued_q + CW'(1);
        rd_vld_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) rd_vld_d[i] = rd_vld_q[i-1];
        infl_d = infl_q + FCW'(issue) - FCW'(push);
        fcnt_d = fcnt_q + FCW'(push) - FCW'(pop);

        if (push) begin
            mem_d[wptr_q] = bram_dout;
            wptr_d        = wptr_q + PW'(1);
        end

        // A completed beat parked in acc_q moves out first; popping resumes once it has left
        if (full_q && out_free) begin
            mv_d   = 1'b1;
            out_d  = acc_q;
            ml_d   = alast_q;
            full_d = 1'b0;
            acc_d  = '0;
            lane_d = '0;
        end

        if (pop) begin
            rptr_d = rptr_q + PW'(1);
            popped_d = popped_q + CW'(1);
            beat[lane_q*W +: W] = mem_q[rptr_q];
            fin      = (popped_q + CW'(1) == num_q);
            complete = fin || (int'(lane_q) == LANES - 1);
`ifdef WSL_CHECKSUM_EN
            csum_d   = csum_q + 16'(mem_q[rptr_q]);
`endif
            if (!complete) begin
                acc_d  = beat;
                lane_d = lane_q + LW'(1);
            end else if (out_free) begin
                mv_d   = 1'b1;
                out_d  = beat;
                ml_d   = fin;
                acc_d  = '0;
                lane_d = '0;
            end else begin
                acc_d   = beat;
                full_d  = 1'b1;
                alast_d = fin;
                lane_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            num_q    <= '0;
            issued_q <= '0;
            popped_q <= '0;
            rd_vld_q <= '0;
            infl_q   <= '0;
            fcnt_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            mem_q    <= '{default: '0};
            acc_q    <= '0;
            lane_q   <= '0;
            full_q   <= 1'b0;
            alast_q  <= 1'b0;
            mv_q     <= 1'b0;
            out_q    <= '0;
            ml_q     <= 1'b0;
`ifdef WSL_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            num_q    <= num_d;
            issued_q <= issued_d;
            popped_q <= popped_d;
            rd_vld_q <= rd_vld_d;
            infl_q   <= infl_d;
            fcnt_q   <= fcnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            mem_q    <= mem_d;
            acc_q    <= acc_d;
            lane_q   <= lane_d;
            full_q   <= full_d;
            alast_q  <= alast_d;
            mv_q     <= mv_d;
            out_q    <= out_d;
            ml_q     <= ml_d;
`ifdef WSL_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign bram_en   = issue;
    assign bram_addr = issue ? (base_q + ADDR_WIDTH'(issued_q)) : '0;
    assign m_valid   = mv_q;
    assign m_data    = out_q;
    assign m_last    = ml_q;
`ifdef WSL_CHECKSUM_EN
    assign checksum  = csum_q;
`endif
endmodule
